// File: rtl/sdram_host_if.sv
// Host-side front end for an SDRAM controller: command latch, 8x16 FWFT write FIFO, req/ack handshake FSM.
// Optional request watchdog enabled by defining SDRAM_HOST_IF_TIMEOUT_EN.
module sdram_host_if (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        host_req_valid,
  input  logic        host_req_we,
  input  logic [21:0] host_req_addr,
  input  logic [3:0]  host_req_len,
  output logic        host_req_ready,
  input  logic [15:0] host_wdata,
  input  logic        host_wdata_valid,
  input  logic        wfifo_rd_en,
  output logic [15:0] wfifo_dout,
  input  logic [15:0] sd_rdata,
  input  logic        sd_rdata_valid,
  output logic [15:0] host_rdata,
  output logic        host_rdata_valid,
  input  logic        sdram_init_done,
  input  logic        sdram_wr_ack,
  input  logic        sdram_rd_ack,
  output logic        sdram_wr_req,
  output logic        sdram_rd_req,
  output logic [7:0]  sdwr_bytes,
  output logic [7:0]  sdrd_bytes,
  output logic [21:0] sys_addr,
  output logic        host_done,
  output logic        wfifo_ovf,
  output logic        host_err
);
  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT_DATA, S_WR_REQ, S_WR_ACK, S_RD_REQ, S_RD_ACK
  } state_t;

  state_t      r_state, w_next;
  logic [21:0] r_addr;
  logic [3:0]  r_len;
  logic        r_wr_req, r_rd_req, r_done;
  logic [15:0] r_rdata;
  logic        r_rvld;
  logic [15:0] r_mem [8];
  logic [2:0]  r_wptr, r_rptr;
  logic [3:0]  r_cnt;
  logic        r_ovf;
  logic        w_accept, w_push, w_pop, w_timeout, w_flush, w_waiting;
  logic        w_wr_req_nxt, w_rd_req_nxt, w_done_nxt;
  logic [3:0]  w_len_eff;

  assign host_req_ready = rst_n & (r_state == S_IDLE) & sdram_init_done;
  assign w_accept       = host_req_valid & host_req_ready;
  assign w_len_eff      = (host_req_len == 4'd0 || host_req_len > 4'd8) ? 4'd8 : host_req_len;
  assign w_waiting      = (r_state == S_WR_REQ && !sdram_wr_ack) || (r_state == S_RD_REQ && !sdram_rd_ack);
  assign w_flush        = w_timeout & (r_state == S_WR_REQ);

`ifdef SDRAM_HOST_IF_TIMEOUT_EN
  logic [9:0] r_wdog;
  logic       r_err;
  // 1023rd consecutive un-acked cycle in a request state aborts the command
  assign w_timeout = w_waiting & (r_wdog == 10'd1022);
  assign host_err  = r_err;
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err  <= w_timeout;
      r_wdog <= w_waiting ? r_wdog + 10'd1 : 10'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign host_err  = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_wr_req_nxt = 1'b0;
    w_rd_req_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE:         if (w_accept) w_next = host_req_we ? S_WR_WAIT_DATA : S_RD_REQ;
      S_WR_WAIT_DATA: if (r_cnt >= r_len) w_next = S_WR_REQ;
      S_WR_REQ: begin
        w_wr_req_nxt = !sdram_wr_ack && !w_timeout;
        if (sdram_wr_ack)   w_next = S_WR_ACK;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WR_ACK: if (!sdram_wr_ack) begin
        w_next     = S_IDLE;
        w_done_nxt = 1'b1;
      end
      S_RD_REQ: begin
        w_rd_req_nxt = !sdram_rd_ack && !w_timeout;
        if (sdram_rd_ack)   w_next = S_RD_ACK;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RD_ACK: if (!sdram_rd_ack) begin
        w_next     = S_IDLE;
        w_done_nxt = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_rvld   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_req <= w_wr_req_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_done   <= w_done_nxt;
      r_rdata  <= sd_rdata;
      r_rvld   <= sd_rdata_valid;
      if (w_accept) begin
        r_addr <= host_req_addr;
        r_len  <= w_len_eff;
      end
    end
  end

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign w_pop  = wfifo_rd_en & (r_cnt != 4'd0);
  assign w_push = host_wdata_valid & ((r_cnt != 4'd8) | w_pop);

  always_ff @(posedge clk_100m) begin
    if (w_push && !w_flush) r_mem[r_wptr] <= host_wdata;
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (host_wdata_valid && !w_push) r_ovf <= 1'b1;
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 3'd1;
        if (w_pop)  r_rptr <= r_rptr + 3'd1;
        r_cnt <= r_cnt + {3'b0, w_push} - {3'b0, w_pop};
      end
    end
  end

  assign wfifo_dout       = (r_cnt != 4'd0) ? r_mem[r_rptr] : 16'h0;
  assign wfifo_ovf        = r_ovf;
  assign sdram_wr_req     = r_wr_req;
  assign sdram_rd_req     = r_rd_req;
  assign sdwr_bytes       = {4'b0, r_len};
  assign sdrd_bytes       = {4'b0, r_len};
  assign sys_addr         = r_addr;
  assign host_done        = r_done;
  assign host_rdata       = r_rdata;
  assign host_rdata_valid = r_rvld;
endmodule

// File: tb/tb_sdram_host_if.sv
// Directed bench for sdram_host_if: handshake timing, length clamp, FIFO order/overflow, reset, optional watchdog.
module tb_sdram_host_if;
  logic        clk_100m = 1'b0, rst_n = 1'b0;
  logic        host_req_valid = 1'b0, host_req_we = 1'b0;
  logic [21:0] host_req_addr = '0;
  logic [3:0]  host_req_len = '0;
  logic        host_req_ready;
  logic [15:0] host_wdata = '0;
  logic        host_wdata_valid = 1'b0, wfifo_rd_en = 1'b0;
  logic [15:0] wfifo_dout;
  logic [15:0] sd_rdata = '0;
  logic        sd_rdata_valid = 1'b0;
  logic [15:0] host_rdata;
  logic        host_rdata_valid;
  logic        sdram_init_done = 1'b0, sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic        sdram_wr_req, sdram_rd_req;
  logic [7:0]  sdwr_bytes, sdrd_bytes;
  logic [21:0] sys_addr;
  logic        host_done, wfifo_ovf, host_err;
  int          n_chk = 0, n_fail = 0;

  sdram_host_if dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .host_req_valid(host_req_valid), .host_req_we(host_req_we),
    .host_req_addr(host_req_addr), .host_req_len(host_req_len),
    .host_req_ready(host_req_ready),
    .host_wdata(host_wdata), .host_wdata_valid(host_wdata_valid),
    .wfifo_rd_en(wfifo_rd_en), .wfifo_dout(wfifo_dout),
    .sd_rdata(sd_rdata), .sd_rdata_valid(sd_rdata_valid),
    .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
    .sdram_init_done(sdram_init_done), .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdwr_bytes(sdwr_bytes), .sdrd_bytes(sdrd_bytes), .sys_addr(sys_addr),
    .host_done(host_done), .wfifo_ovf(wfifo_ovf), .host_err(host_err)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic cyc();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    host_wdata       = d;
    host_wdata_valid = 1'b1;
    cyc();
    host_wdata_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, wfifo_dout}, {16'h0, exp});
    wfifo_rd_en = 1'b1;
    cyc();
    wfifo_rd_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [21:0] a, input logic [3:0] len);
    host_req_valid = 1'b1;
    host_req_we    = we;
    host_req_addr  = a;
    host_req_len   = len;
    cyc();
    host_req_valid = 1'b0;
  endtask

  initial begin
    // reset state, with init_done already high
    sdram_init_done = 1'b1;
    #22;
    chk("rst_ready", {31'h0, host_req_ready}, 0);
    chk("rst_addr", {10'h0, sys_addr}, 0);
    chk("rst_wrreq", {31'h0, sdram_wr_req}, 0);
    chk("rst_dout", {16'h0, wfifo_dout}, 0);
    chk("rst_bytes", {24'h0, sdwr_bytes}, 0);
    chk("rst_ovf_err", {30'h0, wfifo_ovf, host_err}, 0);
    @(negedge clk_100m);
    sdram_init_done = 1'b0;
    rst_n = 1'b1;
    cyc();

    // no acceptance while init_done low
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 22'h3AAAA; host_req_len = 4'd2;
    cyc(); cyc();
    chk("noinit_ready", {31'h0, host_req_ready}, 0);
    chk("noinit_rdreq", {31'h0, sdram_rd_req}, 0);
    chk("noinit_addr", {10'h0, sys_addr}, 0);
    sdram_init_done = 1'b1;
    #1 chk("init_ready", {31'h0, host_req_ready}, 1);
    cyc();
    host_req_valid = 1'b0;
    chk("acc_addr", {10'h0, sys_addr}, 32'h3AAAA);
    chk("acc_rdbytes", {24'h0, sdrd_bytes}, 2);
    chk("acc_rdreq_lat", {31'h0, sdram_rd_req}, 0);
    #1 chk("busy_ready", {31'h0, host_req_ready}, 0);
    cyc();
    chk("rdreq_hi", {31'h0, sdram_rd_req}, 1);
    sdram_rd_ack = 1'b1; cyc();
    chk("rdreq_lo_ack", {31'h0, sdram_rd_req}, 0);
    chk("rd_done_early", {31'h0, host_done}, 0);
    sdram_rd_ack = 1'b0; cyc();
    chk("rd_done", {31'h0, host_done}, 1);
    cyc();
    chk("rd_done_pulse", {31'h0, host_done}, 0);
    chk("idle_ready", {31'h0, host_req_ready}, 1);

    // full-length write, ack held 3 cycles
    for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i));
    chk("fwft_head", {16'h0, wfifo_dout}, 32'h1000);
    issue(1'b1, 22'h012345, 4'd8);
    chk("wr_addr", {10'h0, sys_addr}, 32'h012345);
    chk("wr_bytes8", {24'h0, sdwr_bytes}, 8);
    chk("wrreq_lat0", {31'h0, sdram_wr_req}, 0);
    cyc();
    chk("wrreq_lat1", {31'h0, sdram_wr_req}, 0);
    cyc();
    chk("wrreq_hi", {31'h0, sdram_wr_req}, 1);
    sdram_wr_ack = 1'b1; cyc();
    chk("wrreq_lo_ack", {31'h0, sdram_wr_req}, 0);
    cyc(); cyc();
    chk("wr_done_held", {31'h0, host_done}, 0);
    sdram_wr_ack = 1'b0; cyc();
    chk("wr_done", {31'h0, host_done}, 1);
    cyc();
    chk("wr_done_pulse", {31'h0, host_done}, 0);
    for (int i = 0; i < 8; i++) pop_chk("drain1", 16'h1000 + 16'(i));
    chk("empty_dout", {16'h0, wfifo_dout}, 0);
    wfifo_rd_en = 1'b1; cyc(); wfifo_rd_en = 1'b0;
    chk("pop_empty", {16'h0, wfifo_dout}, 0);

    // write waits for enough data
    push(16'h2000); push(16'h2001);
    issue(1'b1, 22'h00ABCD, 4'd4);
    chk("wr_bytes4", {24'h0, sdwr_bytes}, 4);
    cyc(); cyc(); cyc();
    chk("wait_data", {31'h0, sdram_wr_req}, 0);
    push(16'h2002); push(16'h2003);
    chk("wait_data2", {31'h0, sdram_wr_req}, 0);
    cyc();
    chk("wait_data3", {31'h0, sdram_wr_req}, 0);
    cyc();
    chk("wr4_req", {31'h0, sdram_wr_req}, 1);
    sdram_wr_ack = 1'b1; cyc();
    sdram_wr_ack = 1'b0; cyc();
    chk("wr4_done", {31'h0, host_done}, 1);
    for (int i = 0; i < 4; i++) pop_chk("drain2", 16'h2000 + 16'(i));

    // read len 0 clamps to 8; rdata pipe; init_done drop mid-op
    issue(1'b0, 22'h3FFFFF, 4'd0);
    chk("rd_bytes0", {24'h0, sdrd_bytes}, 8);
    chk("rd_addr", {10'h0, sys_addr}, 32'h3FFFFF);
    sdram_init_done = 1'b0;
    sd_rdata = 16'hBEEF; sd_rdata_valid = 1'b1;
    cyc();
    sd_rdata_valid = 1'b0;
    chk("rdata", {16'h0, host_rdata}, 32'hBEEF);
    chk("rdata_vld", {31'h0, host_rdata_valid}, 1);
    chk("rdreq_noinit", {31'h0, sdram_rd_req}, 1);
    cyc();
    chk("rdata_vld_lo", {31'h0, host_rdata_valid}, 0);
    sdram_rd_ack = 1'b1; cyc();
    sdram_rd_ack = 1'b0; cyc();
    chk("rd0_done", {31'h0, host_done}, 1);
    chk("noinit_blocked", {31'h0, host_req_ready}, 0);
    sdram_init_done = 1'b1;
    #1 chk("reinit_ready", {31'h0, host_req_ready}, 1);
    issue(1'b0, 22'h155555, 4'd12);
    chk("rd_bytes12", {24'h0, sdrd_bytes}, 8);
    cyc();
    sdram_rd_ack = 1'b1; cyc();
    sdram_rd_ack = 1'b0; cyc();
    chk("rd12_done", {31'h0, host_done}, 1);

    // overflow and push+pop while full
    for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i));
    chk("full_no_ovf", {31'h0, wfifo_ovf}, 0);
    push(16'h3008);
    chk("ovf_set", {31'h0, wfifo_ovf}, 1);
    host_wdata = 16'h3100; host_wdata_valid = 1'b1; wfifo_rd_en = 1'b1;
    cyc();
    host_wdata_valid = 1'b0; wfifo_rd_en = 1'b0;
    for (int i = 1; i < 8; i++) pop_chk("drain3", 16'h3000 + 16'(i));
    pop_chk("drain3_tail", 16'h3100);
    chk("drain3_empty", {16'h0, wfifo_dout}, 0);
    chk("ovf_sticky", {31'h0, wfifo_ovf}, 1);

    // reset mid-transaction
    push(16'h4000);
    issue(1'b1, 22'h2AAAAA, 4'd8);
    chk("pre_rst_addr", {10'h0, sys_addr}, 32'h2AAAAA);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", {10'h0, sys_addr}, 0);
    chk("mid_rst_dout", {16'h0, wfifo_dout}, 0);
    chk("mid_rst_bytes", {24'h0, sdwr_bytes}, 0);
    chk("mid_rst_ovf", {31'h0, wfifo_ovf}, 0);
    @(negedge clk_100m);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", {31'h0, host_req_ready}, 1);
    chk("post_rst_wrreq", {31'h0, sdram_wr_req}, 0);

`ifdef SDRAM_HOST_IF_TIMEOUT_EN
    begin
      int n;
      n = 0;
      issue(1'b0, 22'h000100, 4'd1);
      while (n < 1100 && !host_err) begin
        cyc();
        n++;
        if (n == 500) chk("to_req_mid", {31'h0, sdram_rd_req}, 1);
      end
      chk("to_cycles", n, 1023);
      chk("to_err", {31'h0, host_err}, 1);
      chk("to_req_drop", {31'h0, sdram_rd_req}, 0);
      chk("to_no_done", {31'h0, host_done}, 0);
      chk("to_ready", {31'h0, host_req_ready}, 1);
      cyc();
      chk("to_err_pulse", {31'h0, host_err}, 0);
    end
`else
    chk("err_const", {31'h0, host_err}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
